// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator:
// RV32I width codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    DONE
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane datapath: load byte/half extract with sign/zero
// extension, and store byte/half merge into a full word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] ld_word,
  input  logic [WIDTH-1:0] st_base,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] st_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = ld_word[{lane, 3'b000} +: 8];
    half_v  = ld_word[{lane[1], 4'b0000} +: 16];
    ld_data = ld_word;
    unique case (funct3)
      F3_B:    ld_data = {{(WIDTH-8){byte_v[7]}}, byte_v};
      F3_BU:   ld_data = {{(WIDTH-8){1'b0}}, byte_v};
      F3_H:    ld_data = {{(WIDTH-16){half_v[15]}}, half_v};
      F3_HU:   ld_data = {{(WIDTH-16){1'b0}}, half_v};
      default: ld_data = ld_word;
    endcase
  end

  // Only the addressed lane of the old word is replaced
  always_comb begin
    st_word = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        st_word = st_base;
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        st_word = st_base;
        st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator on a word-only data memory port;
// sub-word stores are done as read-modify-write.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_a,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam logic [WIDTH-1:0] LIMIT =
    WIDTH'(DEPTH_WORDS * 4);

  state_e           state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             f3_bad, mis, bad;
  logic [WIDTH-1:0] ld_data, st_word;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3  (f3_q),
    .lane    (addr_q[1:0]),
    .ld_word (mem_rd),
    .st_base (word_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Request screening happens before any memory access
  always_comb begin
    if (is_store)
      f3_bad = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      f3_bad = !(funct3 inside
        {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    mis = 1'b0;
    unique case (1'b1)
      (funct3[1:0] == 2'b01): mis = addr[0];
      (funct3[1:0] == 2'b10): mis = |addr[1:0];
      default:                mis = 1'b0;
    endcase
    bad = f3_bad | mis | (addr >= LIMIT);
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wd     = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          is_store_d = is_store;
          f3_d       = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          err_d      = bad;
          state_d    = bad ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (!is_store_q) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (f3_q[1:0] == 2'b10) begin
          mem_we  = 1'b1;
          mem_wd  = wdata_q;
          state_d = DONE;
        end else begin
          word_d  = mem_rd;
          state_d = MERGE;
        end
      end
      MERGE: begin
        mem_we  = 1'b1;
        mem_wd  = st_word;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign err   = done & err_q;
  assign rdata = rdata_q;
  assign mem_a = {2'b00, addr_q[WIDTH-1:2]};

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator with a word memory model,
// directed vectors, corner sequences and random ops.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  localparam int W = 32;
  localparam int D = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, is_store;
  logic [2:0]    funct3;
  logic [W-1:0]  addr, wdata;
  logic          busy, done, err;
  logic [W-1:0]  rdata, mem_a, mem_wd, mem_rd;
  logic          mem_we;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  ref_mem [D];
  logic          pre_we;
  logic [5:0]    pre_idx;
  logic [W-1:0]  pre_val;
  int            we_total = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.WIDTH(W), .DEPTH_WORDS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_a    (mem_a),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  assign mem_rd = (mem_a < D) ? mem[mem_a[5:0]] : '0;

  always @(posedge clk) begin
    if (mem_we && mem_a < D) mem[mem_a[5:0]] <= mem_wd;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  always @(posedge clk) if (mem_we) we_total++;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic preload(input int idx,
                         input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = idx[5:0];
    pre_val = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run_op(input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        output int lat,
                        output logic e,
                        output logic [31:0] rd,
                        output int wec);
    int w0;
    w0       = we_total;
    req      = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    e  = err;
    rd = rdata;
    @(posedge clk);
    #1 wec = we_total - w0;
  endtask

  // Reference: arithmetic on the byte-addressed memory image
  function automatic void model(input logic st,
                                input logic [2:0] f3,
                                input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic e,
                                output int lat,
                                output logic [31:0] ld,
                                output logic [31:0] nw);
    int size;
    longint w, m, v, sh, wdl;
    size = (f3[1:0] == 2'd0) ? 1 :
           (f3[1:0] == 2'd1) ? 2 : 4;
    if (st) e = (f3 > 3'd2);
    else e = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (a >= 32'd256) e = 1'b1;
    else if ((a % size) != 0) e = 1'b1;
    w = 0;
    if (a < 32'd256) w = {32'b0, ref_mem[a[7:2]]};
    wdl = {32'b0, wd};
    sh = (a % 4) * 8;
    m = ((64'sd1 <<< (size * 8)) - 1) << sh;
    v = (w & m) >> sh;
    if (!st && !f3[2] && size < 4 &&
        v >= (64'sd1 <<< (size * 8 - 1)))
      v = v - (64'sd1 <<< (size * 8));
    ld = v[31:0];
    v = (w & ~m) | ((wdl << sh) & m);
    nw = v[31:0];
    lat = e ? 1 : (st && size < 4) ? 3 : 2;
  endfunction

  typedef struct {
    logic        pre;
    logic [31:0] pre_val;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e;
    int          lat;
    logic [31:0] rd;
    int          we;
    int          widx;
    logic [31:0] word;
  } vec_t;

  vec_t tv [13];

  int          lat, wec, e_lat;
  logic        e, e_err;
  logic [31:0] rd, e_ld, e_nw, exp_rd;
  logic        r_st;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_wd;
  int          w0;

  initial begin
    tv[0]  = '{1, 32'h8081_F0F1, 0, F3_B,  32'h0C, 0,
               0, 2, 32'hFFFF_FFF1, 0, 3, 32'h8081_F0F1};
    tv[1]  = '{0, 0, 0, F3_BU, 32'h0D, 0,
               0, 2, 32'h0000_00F0, 0, 3, 32'h8081_F0F1};
    tv[2]  = '{0, 0, 0, F3_H,  32'h0E, 0,
               0, 2, 32'hFFFF_8081, 0, 3, 32'h8081_F0F1};
    tv[3]  = '{0, 0, 0, F3_HU, 32'h0E, 0,
               0, 2, 32'h0000_8081, 0, 3, 32'h8081_F0F1};
    tv[4]  = '{0, 0, 0, F3_W,  32'h0C, 0,
               0, 2, 32'h8081_F0F1, 0, 3, 32'h8081_F0F1};
    tv[5]  = '{1, 32'h1122_3344, 1, F3_B, 32'h0D, 32'hAA,
               0, 3, 32'h8081_F0F1, 1, 3, 32'h1122_AA44};
    tv[6]  = '{1, 0, 1, F3_H, 32'h12, 32'hBEEF,
               0, 3, 32'h8081_F0F1, 1, 4, 32'hBEEF_0000};
    tv[7]  = '{1, 0, 1, F3_W, 32'h00, 32'hDEAD_BEEF,
               0, 2, 32'h8081_F0F1, 1, 0, 32'hDEAD_BEEF};
    tv[8]  = '{0, 0, 1, F3_W, 32'h02, 32'h1234_5678,
               1, 1, 32'h8081_F0F1, 0, 0, 32'hDEAD_BEEF};
    tv[9]  = '{0, 0, 0, F3_H, 32'h01, 0,
               1, 1, 32'h8081_F0F1, 0, 0, 32'hDEAD_BEEF};
    tv[10] = '{0, 0, 0, 3'b011, 32'h0C, 0,
               1, 1, 32'h8081_F0F1, 0, 3, 32'h1122_AA44};
    tv[11] = '{0, 0, 0, F3_W, 32'h100, 0,
               1, 1, 32'h8081_F0F1, 0, 0, 32'hDEAD_BEEF};
    tv[12] = '{0, 0, 0, F3_BU, 32'h0D, 0,
               0, 2, 32'h0000_00AA, 0, 3, 32'h1122_AA44};

    reset = 1'b1;
    req = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_wd", mem_wd, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      if (tv[i].pre) preload(tv[i].widx, tv[i].pre_val);
      run_op(tv[i].st, tv[i].f3, tv[i].a, tv[i].wd,
             lat, e, rd, wec);
      check($sformatf("v%0d_err", i), {31'b0, e},
            {31'b0, tv[i].e});
      check($sformatf("v%0d_lat", i), lat, tv[i].lat);
      check($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      check($sformatf("v%0d_we", i), wec, tv[i].we);
      check($sformatf("v%0d_word", i),
            mem[tv[i].widx], tv[i].word);
      check($sformatf("v%0d_idle", i), {31'b0, busy}, 0);
    end

    // Reset lands in MERGE of an SB
    preload(5, 32'h5566_7788);
    req = 1'b1; is_store = 1'b1; funct3 = F3_B;
    addr = 32'h14; wdata = 32'hCC;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 check("merge_we", {31'b0, mem_we}, 1);
    w0 = we_total;
    reset = 1'b1;
    #1;
    check("rstm_busy", {31'b0, busy}, 0);
    check("rstm_we", {31'b0, mem_we}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check("rstm_wecnt", we_total - w0, 0);
    check("rstm_word", mem[5], 32'h5566_7788);
    check("rstm_rdata", rdata, 0);

    // req held high while busy must not start a store
    preload(6, 32'h0BAD_F00D);
    preload(7, 32'h7777_7777);
    w0 = we_total;
    req = 1'b1; is_store = 1'b0; funct3 = F3_W;
    addr = 32'h18; wdata = 0;
    @(posedge clk);
    #1;
    is_store = 1'b1; addr = 32'h1C;
    wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("busy_done", {31'b0, done}, 1);
    check("busy_rdata", rdata, 32'h0BAD_F00D);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("busy_idle", {31'b0, busy}, 0);
    check("busy_nodone", {31'b0, done}, 0);
    check("busy_wecnt", we_total - w0, 0);
    check("busy_word", mem[7], 32'h7777_7777);

    // Random ops against the reference model
    reset = 1'b1;
    #1 reset = 1'b0;
    exp_rd = '0;
    for (int i = 0; i < D; i++) preload(i, $urandom);
    for (int i = 0; i < 250; i++) begin
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        r_a = $urandom_range(256, 511);
      else
        r_a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 0)
        r_a[1:0] = 2'b00;
      r_wd = $urandom;
      model(r_st, r_f3, r_a, r_wd, e_err, e_lat, e_ld, e_nw);
      run_op(r_st, r_f3, r_a, r_wd, lat, e, rd, wec);
      if (!e_err && !r_st) exp_rd = e_ld;
      if (!e_err && r_st) ref_mem[r_a[7:2]] = e_nw;
      check($sformatf("r%0d_err", i), {31'b0, e},
            {31'b0, e_err});
      check($sformatf("r%0d_lat", i), lat, e_lat);
      check($sformatf("r%0d_rdata", i), rd, exp_rd);
      check($sformatf("r%0d_we", i), wec,
            (r_st && !e_err) ? 1 : 0);
      if (r_a < 32'd256)
        check($sformatf("r%0d_word", i),
              mem[r_a[7:2]], ref_mem[r_a[7:2]]);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
